// File: rtl/tdm_demux_8_if.sv
// tdm_demux_8_if: bundle between a serial TDM source and the tdm_demux_8
// receiver.
//   din, din_valid, sof : serial stream, one bit per valid cycle; sof marks
//                         the channel-0 bit of a frame.
//   dout                : last completed frame, dout[k] = slot k.
//   frame_valid         : one-cycle pulse when dout is updated.
//   frame_err           : one-cycle pulse when a partial frame is aborted.
//   ch_sel              : slot index the next non-sof bit is written to.
//   busy                : high while a frame is being collected.
// master = stream source / frame consumer, slave = the receiver.
interface tdm_demux_8_if #(
  parameter int CHANNELS = 8,
  parameter int SEL_W    = $clog2(CHANNELS)
);
  logic                din;
  logic                din_valid;
  logic                sof;
  logic [CHANNELS-1:0] dout;
  logic                frame_valid;
  logic                frame_err;
  logic [SEL_W-1:0]    ch_sel;
  logic                busy;

  modport master (
    output din, din_valid, sof,
    input  dout, frame_valid, frame_err, ch_sel, busy
  );

  modport slave (
    input  din, din_valid, sof,
    output dout, frame_valid, frame_err, ch_sel, busy
  );
endinterface

// File: rtl/tdm_demux_8.sv
// tdm_demux_8: time-division demultiplexer / serial-to-parallel receiver.
// Takes the serial line of an 8:1 channel-select mux (one bit per valid
// cycle, sof on channel 0), steers each bit into its slot and presents the
// finished frame in parallel.
// Ports:
//   clk  : system clock, rising edge.
//   rst  : synchronous, active-high reset.
//   bus  : tdm_demux_8_if.slave (din, din_valid, sof in;
//          dout, frame_valid, frame_err, ch_sel, busy out).
module tdm_demux_8 #(
  parameter int CHANNELS = 8,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input logic          clk,
  input logic          rst,
  tdm_demux_8_if.slave bus
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;

  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(CHANNELS - 1);
  localparam logic [SEL_W-1:0] SLOT_ONE  = SEL_W'(1);

  logic [0:0]          state_q, state_d;
  logic [SEL_W-1:0]    cnt_q, cnt_d;
  logic [CHANNELS-1:0] shadow_q, shadow_d;
  logic [CHANNELS-1:0] dout_q, dout_d;
  logic                frame_valid_q, frame_valid_d;
  logic                frame_err_q, frame_err_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shadow_d      = shadow_q;
    dout_d        = dout_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;

    // sof without din_valid carries no bit and is ignored everywhere.
    if (bus.din_valid) begin
      case (state_q)
        IDLE: begin
          // Non-sof bits while idle belong to no frame and are dropped.
          if (bus.sof) begin
            shadow_d[0] = bus.din;
            cnt_d       = SLOT_ONE;
            state_d     = COLLECT;
          end
        end
        default: begin
          if (bus.sof) begin
            // Early sof: flag the aborted frame, the sof bit opens a new one.
            frame_err_d = 1'b1;
            shadow_d[0] = bus.din;
            cnt_d       = SLOT_ONE;
          end else if (cnt_q == LAST_SLOT) begin
            // Last slot goes straight to dout so the frame lands on this edge.
            dout_d        = {bus.din, shadow_q[CHANNELS-2:0]};
            frame_valid_d = 1'b1;
            cnt_d         = '0;
            state_d       = IDLE;
          end else begin
            shadow_d[cnt_q] = bus.din;
            cnt_d           = cnt_q + SLOT_ONE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      shadow_q      <= '0;
      dout_q        <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shadow_q      <= shadow_d;
      dout_q        <= dout_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign bus.dout        = dout_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.ch_sel      = cnt_q;
  assign bus.busy        = (state_q == COLLECT);

endmodule

// File: tb/tb_tdm_demux_8.sv
// Testbench for tdm_demux_8: scenario tasks drive the serial stream, expected
// frames go into a queue as they are sent and are popped when frame_valid
// shows up.
module tb_tdm_demux_8;
  localparam int CHANNELS = 8;
  localparam int SEL_W    = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tdm_demux_8_if #(.CHANNELS(CHANNELS), .SEL_W(SEL_W)) bus ();

  tdm_demux_8 #(.CHANNELS(CHANNELS), .SEL_W(SEL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int fv_cnt  = 0;
  int fe_cnt  = 0;
  int last_fv = 0;
  int prev_fv = 0;
  logic [7:0] exp_q[$];

  // One clock cycle: observe outputs at the falling edge (scoreboard pop on
  // frame_valid), then apply the inputs for the next rising edge.
  task automatic tick(input logic v, input logic s, input logic d);
    logic [7:0] e;
    @(negedge clk);
    cyc++;
    if (bus.frame_valid === 1'b1) begin
      fv_cnt++;
      prev_fv = last_fv;
      last_fv = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_frame_valid: dout=%h, no frame was expected", bus.dout);
      end else begin
        e = exp_q.pop_front();
        if (bus.dout !== e) begin
          errors++;
          $display("FAIL frame_dout: got %h, expected %h", bus.dout, e);
        end
      end
    end
    if (bus.frame_err === 1'b1) fe_cnt++;
    checks++;
    if (bus.frame_valid === 1'b1 && bus.frame_err === 1'b1) begin
      errors++;
      $display("FAIL fv_fe_overlap: frame_valid and frame_err both 1, expected at most one");
    end
    bus.din_valid = v;
    bus.sof       = s;
    bus.din       = d;
  endtask

  task automatic send_frame(input logic [7:0] val);
    for (int i = 0; i < 8; i++) tick(1'b1, (i == 0), val[i]);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.din_valid = 1'b0;
    bus.sof       = 1'b0;
    bus.din       = 1'b0;
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.dout !== 8'h00 || bus.frame_valid !== 1'b0 || bus.frame_err !== 1'b0 ||
        bus.ch_sel !== 3'd0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: dout=%h fv=%b fe=%b ch_sel=%0d busy=%b, expected all 0",
               bus.dout, bus.frame_valid, bus.frame_err, bus.ch_sel, bus.busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int fv0 = fv_cnt;
    exp_q.push_back(8'b01010101);
    send_frame(8'b01010101);
    tick(1'b0, 1'b0, 1'b0);
    checks++;
    if (fv_cnt !== fv0 + 1 || bus.busy !== 1'b0 || bus.ch_sel !== 3'd0) begin
      errors++;
      $display("FAIL basic_end: frames=%0d busy=%b ch_sel=%0d, expected 1 frame busy=0 ch_sel=0",
               fv_cnt - fv0, bus.busy, bus.ch_sel);
    end
    tick(1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.frame_valid !== 1'b0 || bus.dout !== 8'h55) begin
      errors++;
      $display("FAIL basic_pulse_width: fv=%b dout=%h, expected fv=0 dout=55", bus.frame_valid, bus.dout);
    end
  endtask

  task automatic test_gaps;
    int fv0 = fv_cnt;
    // Non-sof bits while idle, plus sof without din_valid: all ignored.
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.busy !== 1'b0 || bus.ch_sel !== 3'd0) begin
      errors++;
      $display("FAIL nosof_ignored: busy=%b ch_sel=%0d, expected busy=0 ch_sel=0", bus.busy, bus.ch_sel);
    end
    exp_q.push_back(8'b00001111);
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.ch_sel !== 3'd3 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL gap_hold1: ch_sel=%0d busy=%b, expected ch_sel=3 busy=1", bus.ch_sel, bus.busy);
    end
    tick(1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.ch_sel !== 3'd3) begin
      errors++;
      $display("FAIL gap_hold2: ch_sel=%0d, expected 3", bus.ch_sel);
    end
    tick(1'b1, 1'b0, 1'b1);
    for (int i = 4; i < 8; i++) tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    checks++;
    if (fv_cnt !== fv0 + 1 || bus.dout !== 8'h0F) begin
      errors++;
      $display("FAIL gap_frame: frames=%0d dout=%h, expected 1 frame dout=0f", fv_cnt - fv0, bus.dout);
    end
  endtask

  task automatic test_early_sof;
    logic [7:0] val = 8'b01100110;
    int fe0 = fe_cnt;
    int fv0 = fv_cnt;
    exp_q.push_back(val);
    tick(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b1, val[0]);
    tick(1'b1, 1'b0, val[1]);
    checks++;
    if (bus.frame_err !== 1'b1 || bus.dout !== 8'h0F || bus.ch_sel !== 3'd1) begin
      errors++;
      $display("FAIL early_sof_err: fe=%b dout=%h ch_sel=%0d, expected fe=1 dout=0f ch_sel=1",
               bus.frame_err, bus.dout, bus.ch_sel);
    end
    for (int i = 2; i < 8; i++) tick(1'b1, 1'b0, val[i]);
    tick(1'b0, 1'b0, 1'b0);
    checks++;
    if (fe_cnt !== fe0 + 1 || fv_cnt !== fv0 + 1 || bus.dout !== val) begin
      errors++;
      $display("FAIL early_sof_end: fe_pulses=%0d frames=%0d dout=%h, expected 1, 1, %h",
               fe_cnt - fe0, fv_cnt - fv0, bus.dout, val);
    end
  endtask

  task automatic test_back_to_back;
    int fe0 = fe_cnt;
    int fv0 = fv_cnt;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    send_frame(8'hA5);
    send_frame(8'h3C);
    tick(1'b0, 1'b0, 1'b0);
    checks++;
    if (fv_cnt !== fv0 + 2 || last_fv - prev_fv !== 8 || fe_cnt !== fe0 || bus.dout !== 8'h3C) begin
      errors++;
      $display("FAIL back_to_back: frames=%0d spacing=%0d fe_pulses=%0d dout=%h, expected 2, 8, 0, 3c",
               fv_cnt - fv0, last_fv - prev_fv, fe_cnt - fe0, bus.dout);
    end
  endtask

  task automatic test_reset_mid;
    int fe0 = fe_cnt;
    int fv0 = fv_cnt;
    tick(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    checks++;
    if (bus.dout !== 8'h00 || bus.busy !== 1'b0 || bus.ch_sel !== 3'd0 ||
        bus.frame_valid !== 1'b0 || bus.frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: dout=%h busy=%b ch_sel=%0d fv=%b fe=%b, expected all 0",
               bus.dout, bus.busy, bus.ch_sel, bus.frame_valid, bus.frame_err);
    end
    exp_q.push_back(8'hFF);
    send_frame(8'hFF);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    checks++;
    if (fv_cnt !== fv0 + 1 || fe_cnt !== fe0 || bus.dout !== 8'hFF) begin
      errors++;
      $display("FAIL reset_mid_frame: frames=%0d fe_pulses=%0d dout=%h, expected 1, 0, ff",
               fv_cnt - fv0, fe_cnt - fe0, bus.dout);
    end
  endtask

  task automatic test_loopback;
    logic [7:0] inp = 8'b01010101;
    logic       mux_out;
    int fv0 = fv_cnt;
    exp_q.push_back(inp);
    // Behavioural 8:1 mux stepping sel 0..7 onto the serial line.
    for (int sel = 0; sel < 8; sel++) begin
      mux_out = inp[sel];
      tick(1'b1, (sel == 0), mux_out);
    end
    tick(1'b0, 1'b0, 1'b0);
    checks++;
    if (fv_cnt !== fv0 + 1 || bus.dout !== inp || exp_q.size() != 0) begin
      errors++;
      $display("FAIL loopback: frames=%0d dout=%h pending=%0d, expected 1 frame dout=%h pending=0",
               fv_cnt - fv0, bus.dout, exp_q.size(), inp);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_gaps;
    test_early_sof;
    test_back_to_back;
    test_reset_mid;
    test_loopback;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdm_demux_8.md
Name: tdm_demux_8

Overview:
Time-division demultiplexer and serial-to-parallel receiver. It is the receive end of the 8:1 channel-select mux path. The mux drives channel k onto a single serial line when sel=k. This block takes that serial stream, one bit per valid cycle, with a start-of-frame marker on channel 0. It steers each bit into its channel slot and presents the complete frame in parallel. It sits directly after the serial line that the demux/mux stage drives.

Parameters:
CHANNELS, 8, number of time slots per frame; must be a power of two, range 2..256.
SEL_W, 3, channel counter width, equal to log2(CHANNELS); fixed by CHANNELS.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  synchronous, active-high reset.
din  input  1  serial data bit for the current slot.
din_valid  input  1  din is valid this cycle; a bit is accepted only when this is 1.
sof  input  1  start of frame; qualifies a din_valid cycle as the channel-0 bit.
dout  output  CHANNELS  last completed frame; dout[k] = bit received in slot k.
frame_valid  output  1  one-cycle pulse when dout is updated.
frame_err  output  1  one-cycle pulse when a partial frame is aborted by an early sof.
ch_sel  output  SEL_W  slot index the next accepted non-sof bit will be written to.
busy  output  1  high while a frame is being collected.

Behaviour:
- Reset, on any clk edge with rst=1: dout=0, frame_valid=0, frame_err=0, ch_sel=0, busy=0, shadow register=0, state=IDLE. Reset overrides all other inputs.
- Reset mid-frame discards the partial frame. No frame_valid or frame_err is generated.
- The FSM has two states, IDLE and COLLECT. busy = (state==COLLECT). ch_sel is the registered slot counter cnt.
- IDLE, din_valid=1 and sof=1: shadow[0]<=din, cnt<=1, go to COLLECT.
- IDLE, din_valid=1 and sof=0: the bit is dropped and no state change occurs.
- IDLE, din_valid=0: hold.
- COLLECT, din_valid=0: hold everything. Gaps of any length are allowed.
- COLLECT, din_valid=1, sof=0, cnt<CHANNELS-1: shadow[cnt]<=din, cnt<=cnt+1.
- COLLECT, din_valid=1, sof=0, cnt==CHANNELS-1 (last slot):
  - dout <= {din, shadow[CHANNELS-2:0]} on the same edge.
  - frame_valid=1 for the following cycle only.
  - cnt<=0 (wrap), go to IDLE.
- COLLECT, din_valid=1, sof=1 (early sof):
  - frame_err=1 for the following cycle; the partial frame is discarded and dout is unchanged.
  - The sof bit starts a new frame: shadow[0]<=din, cnt<=1, stay in COLLECT.
- sof with din_valid=0 is ignored in every state.
- Latency: dout and frame_valid are visible one cycle after the edge that samples the last-slot bit.
- dout holds its value until the next complete frame. frame_valid and frame_err are never high in the same cycle.
- Back-to-back frames: a sof bit in the cycle right after the last slot is accepted. The IDLE-to-COLLECT transition costs no bubble.
- The shadow register is not cleared between frames. Each slot is always overwritten before use.
- Slot mapping matches the mux: slot k lands in dout[k]. Serializing inp with sel=0..7 therefore reproduces inp exactly.

Test Plan:
- Basic frame: rst for 2 cycles, then 8 consecutive valid bits 1,0,1,0,1,0,1,0 with sof on the first -> one cycle after the 8th bit, dout=8'b01010101 and frame_valid=1 for exactly one cycle; busy=0, ch_sel=0.
- Gaps and no-sof: 3 valid bits without sof -> ignored, busy stays 0. Then the frame 1,1,1,1,0,0,0,0 with sof on the first and din_valid low for 2 cycles after the 3rd bit -> dout=8'b00001111. ch_sel holds at 3 during the gap.
- Early sof: send sof plus 4 bits (all 1), then sof plus 8 bits 0,1,1,0,0,1,1,0 -> frame_err pulses once after the second sof; dout stays at its previous value until the final frame_valid, then dout=8'b01100110.
- Back-to-back: two full frames, 8'hA5 then 8'h3C, with no idle cycle between -> frame_valid pulses exactly 8 cycles apart; dout=8'hA5, then 8'h3C; no frame_err.
- Reset mid-frame: sof plus 5 bits, then rst for 1 cycle, then a full frame 8'hFF -> no pulse at reset; dout=0 after reset, then dout=8'hFF with a single frame_valid.
- Loopback: the 8:1 mux is driven with inp=8'b01010101, sel stepped 000..111, and its output is fed to din with sof at sel=000 -> dout equals inp.
